// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Drives a fetch address to a combinational program memory. The returned
//   words are captured, together with their byte addresses, into a 2-entry
//   prefetch FIFO whose head is offered to the decode stage. A redirect
//   (taken branch/jump) flushes the FIFO and restarts fetch at the
//   word-aligned target address.
//
// Ports:
//   clk                 in   rising-edge clock for all state
//   reset               in   asynchronous active-low reset
//   FetchAddress        out  byte address to program memory (= fetch PC)
//   MemInstruction      in   word returned for FetchAddress in the same cycle
//   Redirect            in   flush and restart fetch at RedirectAddress
//   RedirectAddress     in   redirect target byte address
//   InstrReady          in   decode accepts the head instruction this cycle
//   InstrValid          out  head of the prefetch FIFO is valid
//   Instruction         out  head instruction word
//   InstrPC             out  byte address of the head instruction
//   InstrPCPlus4        out  InstrPC + 4 (modulo 2^32)
//   MisalignedRedirect  out  one-cycle pulse after a redirect whose target
//                            had nonzero bits [1:0]
//   StallCount          out  (IFU_STALL_COUNTER_EN only) saturating count of
//                            cycles with InstrValid=1 and InstrReady=0
//
// Configuration:
//   IFU_STALL_COUNTER_EN  define to add the StallCount output and counter.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] FetchAddress,
  input  logic [DATA_WIDTH-1:0] MemInstruction,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectAddress,
  input  logic                  InstrReady,
  output logic                  InstrValid,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] InstrPC,
  output logic [DATA_WIDTH-1:0] InstrPCPlus4,
`ifdef IFU_STALL_COUNTER_EN
  output logic [15:0]           StallCount,
`endif
  output logic                  MisalignedRedirect
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_q    [2];
  logic [DATA_WIDTH-1:0] pc_d    [2];
  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [DATA_WIDTH-1:0] instr_d [2];
  logic [1:0]            count_q, count_d;
  logic                  misaligned_q, misaligned_d;

  logic pop;
  logic push;
  logic wr_slot_one;

  // Redirect wins over both pop and push; the flushed entries are never
  // handed to decode.
  assign pop  = (count_q != 2'd0) && InstrReady && !Redirect;
  assign push = !Redirect && ((count_q != 2'd2) || pop);

  // Entry 0 is always the head. A new word lands behind whatever remains
  // after this edge's pop.
  assign wr_slot_one = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise the tool infers a latch.
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    count_d      = count_q;
    misaligned_d = 1'b0;

    if (Redirect) begin
      count_d      = 2'd0;
      fetch_pc_d   = {RedirectAddress[DATA_WIDTH-1:2], 2'b00};
      misaligned_d = |RedirectAddress[1:0];
    end else begin
      // Shift the second entry forward only when it exists; popping the
      // last entry leaves entry 0 untouched so the head outputs hold.
      if (pop && (count_q == 2'd2)) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push) begin
        if (wr_slot_one) begin
          pc_d[1]    = fetch_pc_q;
          instr_d[1] = MemInstruction;
        end else begin
          pc_d[0]    = fetch_pc_q;
          instr_d[0] = MemInstruction;
        end
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the two FIFO entries are reset as well, because the head's
  // contents are visible on Instruction/InstrPC straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      count_q      <= 2'd0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
    end
  end

`ifdef IFU_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (Redirect) begin
      stall_q <= '0;
    end else if (InstrValid && !InstrReady && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign StallCount = stall_q;
`endif

  assign FetchAddress       = fetch_pc_q;
  assign InstrValid         = (count_q != 2'd0);
  assign Instruction        = instr_q[0];
  assign InstrPC            = pc_q[0];
  assign InstrPCPlus4       = pc_q[0] + PC_STEP;
  assign MisalignedRedirect = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. The program memory is a
// combinational model returning 32'h2000_0000 + word index of the address.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [31:0] mem_instr;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        misaligned;
`ifdef IFU_STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_instr = 32'h2000_0000 + {2'b00, fetch_addr[31:2]};

  instruction_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .FetchAddress       (fetch_addr),
    .MemInstruction     (mem_instr),
    .Redirect           (redirect),
    .RedirectAddress    (redirect_addr),
    .InstrReady         (instr_ready),
    .InstrValid         (instr_valid),
    .Instruction        (instruction),
    .InstrPC            (instr_pc),
    .InstrPCPlus4       (instr_pc_plus4),
`ifdef IFU_STALL_COUNTER_EN
    .StallCount         (stall_count),
`endif
    .MisalignedRedirect (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset mid-cycle, then release it 1 unit after an edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b1;
    #3;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_pc4", instr_pc_plus4, 32'h4);
    check("rst_misal", 32'(misaligned), 32'd0);
    check("rst_fetch", fetch_addr, 32'h0);
    step(2);
    reset = 1'b1;

    // Streaming with InstrReady=1: one instruction per cycle.
    check("lat_valid0", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("str_valid%0d", k), 32'(instr_valid), 32'd1);
      check($sformatf("str_pc%0d", k), instr_pc, 32'(4 * k));
      check($sformatf("str_instr%0d", k), instruction, 32'h2000_0000 + 32'(k));
      check($sformatf("str_pc4_%0d", k), instr_pc_plus4, 32'(4 * k + 4));
    end

    // Stall: FIFO fills to two entries and fetch holds.
    do_reset();
    instr_ready = 1'b0;
    step(5);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_pc", instr_pc, 32'h0);
    check("stall_instr", instruction, 32'h2000_0000);
    check("stall_fetch", fetch_addr, 32'h8);
`ifdef IFU_STALL_COUNTER_EN
    check("stall_count", 32'(stall_count), 32'd4);
`endif

    // Redirect while full: flush, old entries never popped.
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0040;
    step();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    check("redir_valid0", 32'(instr_valid), 32'd0);
    check("redir_fetch", fetch_addr, 32'h40);
    check("redir_hold", instruction, 32'h2000_0000);
    check("redir_misal0", 32'(misaligned), 32'd0);
`ifdef IFU_STALL_COUNTER_EN
    check("redir_stall_clr", 32'(stall_count), 32'd0);
`endif
    step();
    check("redir_valid1", 32'(instr_valid), 32'd1);
    check("redir_pc", instr_pc, 32'h40);
    check("redir_instr", instruction, 32'h2000_0010);
    step();
    check("redir_next", instr_pc, 32'h44);

    // Misaligned redirect target.
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0046;
    step();
    redirect = 1'b0;
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_fetch", fetch_addr, 32'h44);
    step();
    check("mis_clear", 32'(misaligned), 32'd0);
    check("mis_pc", instr_pc, 32'h44);

    // Wrap-around at the top of the address space.
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    step();
    check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    check("wrap_pc4_0", instr_pc_plus4, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc4_1", instr_pc_plus4, 32'h0000_0000);
    step();
    check("wrap_pc2", instr_pc, 32'h0000_0000);
    check("wrap_instr2", instruction, 32'h2000_0000);
    check("wrap_misal", 32'(misaligned), 32'd0);

    // Back-to-back redirects: only the last target survives.
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0100;
    step();
    redirect_addr = 32'h0000_0200;
    step();
    redirect = 1'b0;
    check("b2b_valid0", 32'(instr_valid), 32'd0);
    step();
    check("b2b_pc", instr_pc, 32'h200);
    check("b2b_instr", instruction, 32'h2000_0080);

    // Simultaneous push and pop keeps program order.
    do_reset();
    instr_ready = 1'b0;
    step(2);
    instr_ready = 1'b1;
    step();
    check("pp_pc1", instr_pc, 32'h4);
    check("pp_fetch", fetch_addr, 32'hC);
    step();
    check("pp_pc2", instr_pc, 32'h8);
    check("pp_instr2", instruction, 32'h2000_0002);

    // Reset pulse mid-stream at PC 0x20.
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0020;
    step();
    redirect = 1'b0;
    step();
    check("mid_pc", instr_pc, 32'h20);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", instr_pc, 32'h0);
    check("mid_rst_fetch", fetch_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("mid_rel_valid", 32'(instr_valid), 32'd1);
    check("mid_rel_pc", instr_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
